// File: rtl/ysyx_22041207_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041207_wb_stage
// Brief    : Write-back stage. Selects the register-file write data,
//            issues a one-cycle registered write/retire pulse per accepted
//            payload, counts retired instructions and stops on ebreak.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22041207_wb_stage #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      alu_c,
  input  logic [63:0]      pc,
  input  logic [63:0]      ramdout,
  input  logic [63:0]      imm,
  input  logic [63:0]      csrValue,
  input  logic [2:0]       wd_sel,
  input  logic             writeRD,
  input  logic [4:0]       rwddr,
  input  logic             ebreak,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [63:0]      rf_wdata,
  output logic             retire_valid,
  output logic [63:0]      retire_pc,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic [63:0]      halt_pc
);

  localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_rf_we;
  logic [4:0]       r_rf_waddr;
  logic [63:0]      r_rf_wdata;
  logic             r_retire_valid;
  logic [63:0]      r_retire_pc;
  logic [CNT_W-1:0] r_instret;
  logic             r_halted;
  logic [63:0]      r_halt_pc;

  logic             w_ready;
  logic             w_xfer;
  logic [63:0]      w_wdata;

  assign w_ready = (r_state == ST_RUN);
  assign w_xfer  = in_valid && w_ready;

  // Write-data source select; unused encodings write zero.
  always_comb begin
    w_wdata = 64'h0;
    case (wd_sel)
      3'd0:    w_wdata = alu_c;
      3'd1:    w_wdata = ramdout;
      3'd2:    w_wdata = pc + 64'd4;
      3'd3:    w_wdata = imm;
      3'd4:    w_wdata = csrValue;
      default: w_wdata = 64'h0;
    endcase
  end

  // Run/halt control plus registered write-back, retire and counter outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_RUN;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= 5'd0;
      r_rf_wdata     <= 64'h0;
      r_retire_valid <= 1'b0;
      r_retire_pc    <= 64'h0;
      r_instret      <= '0;
      r_halted       <= 1'b0;
      r_halt_pc      <= 64'h0;
    end else begin
      // Pulses drop by default; data fields hold until the next transfer.
      r_rf_we        <= 1'b0;
      r_retire_valid <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_xfer) begin
            r_rf_we        <= writeRD && (rwddr != 5'd0);
            r_rf_waddr     <= rwddr;
            r_rf_wdata     <= w_wdata;
            r_retire_valid <= 1'b1;
            r_retire_pc    <= pc;
            r_instret      <= r_instret + c_ONE;
            if (ebreak) begin
              // The ebreak retires normally, then the stage stops accepting.
              r_state   <= ST_HALTED;
              r_halted  <= 1'b1;
              r_halt_pc <= pc;
            end
          end
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign in_ready     = w_ready;
  assign rf_we        = r_rf_we;
  assign rf_waddr     = r_rf_waddr;
  assign rf_wdata     = r_rf_wdata;
  assign retire_valid = r_retire_valid;
  assign retire_pc    = r_retire_pc;
  assign instret      = r_instret;
  assign halted       = r_halted;
  assign halt_pc      = r_halt_pc;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041207_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22041207_wb_stage
// Brief    : Self-checking bench for the write-back stage (64-bit and 4-bit
//            counter builds driven from the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041207_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] alu_c, pc, ramdout, imm, csrValue;
  logic [2:0]  wd_sel;
  logic        writeRD;
  logic [4:0]  rwddr;
  logic        ebreak;

  logic        in_ready, rf_we, retire_valid, halted;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata, retire_pc, halt_pc;
  logic [63:0] instret;

  logic        in_ready4, rf_we4, retire_valid4, halted4;
  logic [4:0]  rf_waddr4;
  logic [63:0] rf_wdata4, retire_pc4, halt_pc4;
  logic [3:0]  instret4;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        m_we, m_rv, m_halted;
  logic [4:0]  m_waddr;
  logic [63:0] m_wdata, m_rpc, m_hpc, m_instret;

  always #5 clk = ~clk;

  ysyx_22041207_wb_stage #(.CNT_W(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_c(alu_c), .pc(pc), .ramdout(ramdout), .imm(imm), .csrValue(csrValue),
    .wd_sel(wd_sel), .writeRD(writeRD), .rwddr(rwddr), .ebreak(ebreak),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .instret(instret),
    .halted(halted), .halt_pc(halt_pc)
  );

  ysyx_22041207_wb_stage #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .alu_c(alu_c), .pc(pc), .ramdout(ramdout), .imm(imm), .csrValue(csrValue),
    .wd_sel(wd_sel), .writeRD(writeRD), .rwddr(rwddr), .ebreak(ebreak),
    .rf_we(rf_we4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
    .retire_valid(retire_valid4), .retire_pc(retire_pc4), .instret(instret4),
    .halted(halted4), .halt_pc(halt_pc4)
  );

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    in_valid = 1'b0; alu_c = 64'h0; pc = 64'h0; ramdout = 64'h0;
    imm = 64'h0; csrValue = 64'h0; wd_sel = 3'd0; writeRD = 1'b0;
    rwddr = 5'd0; ebreak = 1'b0;
  endtask

  task automatic model_reset();
    m_we = 0; m_rv = 0; m_halted = 0; m_waddr = 0;
    m_wdata = 0; m_rpc = 0; m_hpc = 0; m_instret = 0;
  endtask

  // Apply one clock edge to the model using current inputs.
  task automatic model_step();
    logic [63:0] src [8];
    src[0] = alu_c; src[1] = ramdout; src[2] = pc + 64'd4; src[3] = imm;
    src[4] = csrValue; src[5] = 64'h0; src[6] = 64'h0; src[7] = 64'h0;
    if (in_valid && !m_halted) begin
      m_we      = writeRD && (rwddr != 0);
      m_waddr   = rwddr;
      m_wdata   = src[wd_sel];
      m_rv      = 1'b1;
      m_rpc     = pc;
      m_instret = m_instret + 1;
      if (ebreak) begin
        m_halted = 1'b1;
        m_hpc    = pc;
      end
    end else begin
      m_we = 0;
      m_rv = 0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic tick();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, retire_valid, retire_pc, instret, halted, halt_pc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%0b waddr=%0d wdata=%h rv=%0b rpc=%h instret=%0d halted=%0b hpc=%h, required all zero",
               rf_we, rf_waddr, rf_wdata, retire_valid, retire_pc, instret, halted, halt_pc);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    do_reset();
    // ALU write to x5
    in_valid = 1; alu_c = 64'h1234; wd_sel = 3'd0; writeRD = 1; rwddr = 5'd5; pc = 64'h100;
    tick();
    in_valid = 0;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'h1234 || retire_valid !== 1'b1 || instret !== 64'd1) begin
      errors++;
      $display("FAIL alu_write: got we=%0b waddr=%0d wdata=%h rv=%0b instret=%0d required 1/5/1234/1/1",
               rf_we, rf_waddr, rf_wdata, retire_valid, instret);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || retire_valid !== 1'b0 || rf_wdata !== 64'h1234 || retire_pc !== 64'h100 || instret !== 64'd1) begin
      errors++;
      $display("FAIL idle_hold: got we=%0b rv=%0b wdata=%h rpc=%h instret=%0d required 0/0/1234/100/1",
               rf_we, retire_valid, rf_wdata, retire_pc, instret);
    end
    // pc+4 link
    in_valid = 1; pc = 64'h8000_0000; wd_sel = 3'd2; rwddr = 5'd1; writeRD = 1;
    tick();
    checks++;
    if (rf_wdata !== 64'h8000_0004 || rf_we !== 1'b1 || retire_pc !== 64'h8000_0000) begin
      errors++;
      $display("FAIL pc_plus4: got wdata=%h we=%0b rpc=%h required 80000004/1/80000000", rf_wdata, rf_we, retire_pc);
    end
    pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    checks++;
    if (rf_wdata !== 64'h0) begin
      errors++;
      $display("FAIL pc_plus4_wrap: got wdata=%h required 0", rf_wdata);
    end
    // x0 write suppressed, still retires
    pc = 64'h200; wd_sel = 3'd1; ramdout = 64'hDEAD; rwddr = 5'd0; writeRD = 1;
    tick();
    in_valid = 0;
    checks++;
    if (rf_we !== 1'b0 || retire_valid !== 1'b1 || instret !== 64'd4) begin
      errors++;
      $display("FAIL x0_suppress: got we=%0b rv=%0b instret=%0d required 0/1/4", rf_we, retire_valid, instret);
    end
    // Reserved selects write zero
    in_valid = 1; wd_sel = 3'd6; alu_c = 64'h55; imm = 64'h66; csrValue = 64'h77; rwddr = 5'd9;
    tick();
    in_valid = 0;
    checks++;
    if (rf_wdata !== 64'h0 || rf_we !== 1'b1) begin
      errors++;
      $display("FAIL sel_reserved: got wdata=%h we=%0b required 0/1", rf_wdata, rf_we);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      alu_c    = {$urandom, $urandom};
      pc       = {$urandom, $urandom};
      ramdout  = {$urandom, $urandom};
      imm      = {$urandom, $urandom};
      csrValue = {$urandom, $urandom};
      wd_sel   = 3'($urandom_range(0, 7));
      writeRD  = 1'($urandom_range(0, 1));
      rwddr    = 5'($urandom_range(0, 31));
      ebreak   = (n > 300) && ($urandom_range(0, 31) == 0);
      #1;
      checks++;
      if (in_ready !== !m_halted) begin
        errors++;
        $display("FAIL rand_in_ready[%0d]: got %0b required %0b", n, in_ready, !m_halted);
      end
      tick();
      checks++;
      if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata || retire_valid !== m_rv ||
          retire_pc !== m_rpc || instret !== m_instret || halted !== m_halted || halt_pc !== m_hpc ||
          instret4 !== m_instret[3:0]) begin
        errors++;
        $display("FAIL rand_outputs[%0d]: got we=%0b wa=%0d wd=%h rv=%0b rpc=%h ir=%0d ir4=%0d h=%0b hpc=%h required we=%0b wa=%0d wd=%h rv=%0b rpc=%h ir=%0d ir4=%0d h=%0b hpc=%h",
                 n, rf_we, rf_waddr, rf_wdata, retire_valid, retire_pc, instret, instret4, halted, halt_pc,
                 m_we, m_waddr, m_wdata, m_rv, m_rpc, m_instret, m_instret[3:0], m_halted, m_hpc);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    in_valid = 1; ebreak = 1; pc = 64'h8000_0010; alu_c = 64'h77; wd_sel = 3'd0; writeRD = 1; rwddr = 5'd3;
    tick();
    ebreak = 0;
    checks++;
    if (halted !== 1'b1 || halt_pc !== 64'h8000_0010 || in_ready !== 1'b0 || retire_valid !== 1'b1 ||
        rf_we !== 1'b1 || rf_wdata !== 64'h77 || instret !== 64'd1) begin
      errors++;
      $display("FAIL halt_entry: got h=%0b hpc=%h rdy=%0b rv=%0b we=%0b wd=%h ir=%0d required 1/80000010/0/1/1/77/1",
               halted, halt_pc, in_ready, retire_valid, rf_we, rf_wdata, instret);
    end
    for (int k = 0; k < 5; k++) begin
      pc = 64'h9000 + 64'(k); rwddr = 5'd7;
      tick();
      checks++;
      if (rf_we !== 1'b0 || retire_valid !== 1'b0 || instret !== 64'd1 || halted !== 1'b1 ||
          in_ready !== 1'b0 || halt_pc !== 64'h8000_0010) begin
        errors++;
        $display("FAIL halt_frozen[%0d]: got we=%0b rv=%0b ir=%0d h=%0b rdy=%0b hpc=%h required 0/0/1/1/0/80000010",
                 k, rf_we, retire_valid, instret, halted, in_ready, halt_pc);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Still halted from previous test: reset asynchronously between edges.
    rst_n = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || halt_pc !== 64'h0 || instret !== 64'd0 || in_ready !== 1'b1 || retire_pc !== 64'h0) begin
      errors++;
      $display("FAIL reset_halted: got h=%0b hpc=%h ir=%0d rdy=%0b rpc=%h required 0/0/0/1/0",
               halted, halt_pc, instret, in_ready, retire_pc);
    end
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    // Transfer, then reset while the write pulse is live.
    in_valid = 1; alu_c = 64'hABCD; wd_sel = 3'd0; writeRD = 1; rwddr = 5'd12; pc = 64'h40;
    tick();
    idle_inputs();
    checks++;
    if (rf_we !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_pulse: got we=%0b required 1", rf_we);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rf_we !== 1'b0 || retire_valid !== 1'b0 || rf_wdata !== 64'h0 || rf_waddr !== 5'd0 || instret !== 64'd0) begin
      errors++;
      $display("FAIL reset_pulse: got we=%0b rv=%0b wd=%h wa=%0d ir=%0d required all zero",
               rf_we, retire_valid, rf_wdata, rf_waddr, instret);
    end
    in_valid = 1; rwddr = 5'd4; writeRD = 1;
    @(posedge clk); #1;
    checks++;
    if (rf_we !== 1'b0 || retire_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: got we=%0b rv=%0b required 0/0", rf_we, retire_valid);
    end
    idle_inputs();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_wrap();
    do_reset();
    in_valid = 1; wd_sel = 3'd3; writeRD = 1; rwddr = 5'd2;
    for (int k = 1; k <= 16; k++) begin
      pc = 64'(k * 4); imm = 64'(k);
      tick();
      checks++;
      if (instret4 !== m_instret[3:0] || instret !== m_instret) begin
        errors++;
        $display("FAIL wrap[%0d]: got ir4=%0d ir=%0d required %0d/%0d", k, instret4, instret, m_instret[3:0], m_instret);
      end
    end
    in_valid = 0;
    checks++;
    if (instret4 !== 4'd0 || instret !== 64'd16) begin
      errors++;
      $display("FAIL wrap_final: got ir4=%0d ir=%0d required 0/16", instret4, instret);
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_directed();
    test_random();
    test_halt();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22041207_wb_stage.md
YSYX_22041207_WB_STAGE -- requirements
Module: ysyx_22041207_wb_stage

Interface
REQ-001 Parameter: CNT_W, default 64, width of the retired-instruction counter instret.
REQ-002 clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  ME/WB payload valid this cycle.
REQ-005 in_ready  output  1  stage accepts payload; transfer = in_valid && in_ready.
REQ-006 alu_c, pc, ramdout, imm, csrValue  input  64 each  ME/WB payload data.
REQ-007 wd_sel  input  3  write-data source select.
REQ-008 writeRD  input  1  instruction writes rd.
REQ-009 rwddr  input  5  destination register index.
REQ-010 ebreak  input  1  instruction is ebreak.
REQ-011 rf_we  output  1  register-file write enable, registered.
REQ-012 rf_waddr  output  5  register-file write index, registered.
REQ-013 rf_wdata  output  64  register-file write data, registered.
REQ-014 retire_valid  output  1  one-cycle pulse per retired instruction.
REQ-015 retire_pc  output  64  pc of the instruction retiring this cycle.
REQ-016 instret  output  CNT_W  count of retired instructions.
REQ-017 halted  output  1  core stopped by ebreak.
REQ-018 halt_pc  output  64  pc of the halting ebreak.

Function
REQ-019 Write-data mux: wd_sel 0 -> alu_c; 1 -> ramdout; 2 -> pc+4 (mod 2^64); 3 -> imm; 4 -> csrValue; 5-7 -> 64'h0.
REQ-020 Latency: a payload transferred in cycle N drives rf_we/rf_waddr/rf_wdata and retire_valid/retire_pc in cycle N+1, for exactly one cycle.
REQ-021 rf_we = writeRD && (rwddr != 0) of the transferred payload; x0 writes are suppressed, but the instruction still retires.
REQ-022 With no transfer in cycle N: rf_we=0 and retire_valid=0 in N+1; rf_waddr/rf_wdata/retire_pc hold their previous values.
REQ-023 instret increments by 1 in the cycle retire_valid is high and wraps from all-ones to 0.
REQ-024 FSM states: RUN, HALTED.
REQ-025 RUN: in_ready=1.
REQ-026 RUN -> HALTED on a transfer with ebreak=1; halted=1 and halt_pc = that pc from cycle N+1.
REQ-027 The ebreak itself retires (retire_valid=1, instret+1) and performs its rd write if enabled per REQ-021.
REQ-028 HALTED: in_ready=0, no transfers, rf_we=0, retire_valid=0, instret frozen; exit only by reset.
REQ-029 When in_valid and ebreak are high in the same cycle as the RUN->HALTED transition's triggering transfer, only that payload is consumed; payloads presented later are ignored.
REQ-030 in_valid=0 with any payload values causes no state change.

Reset
REQ-031 rst_n low asynchronously forces: state RUN, rf_we=0, rf_waddr=0, rf_wdata=0, retire_valid=0, retire_pc=0, instret=0, halted=0, halt_pc=0.
REQ-032 After release, in_ready=1 immediately.
REQ-033 Reset asserted mid-operation (including HALTED, or with a pending write pulse) discards all pending output; no rf_we pulse occurs after rst_n falls.

Verification
REQ-034 Transfer alu_c=64'h1234, wd_sel=0, writeRD=1, rwddr=5 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=64'h1234, retire_valid=1, instret=1.
REQ-035 Transfer pc=64'h8000_0000, wd_sel=2, rwddr=1 -> rf_wdata=64'h8000_0004; with pc=64'hFFFF_FFFF_FFFF_FFFC -> rf_wdata=0.
REQ-036 Transfer writeRD=1, rwddr=0, wd_sel=1 -> rf_we=0, retire_valid=1, instret incremented.
REQ-037 Transfer ebreak=1, pc=64'h8000_0010 -> next cycle halted=1, halt_pc=64'h8000_0010, in_ready=0; further in_valid=1 for 5 cycles -> instret unchanged, rf_we=0.
REQ-038 Preload CNT_W=4 build, retire 16 instructions -> instret returns to 0.
REQ-039 Assert rst_n=0 while halted, or one cycle after a transfer -> all outputs zero within the same cycle, halted=0, in_ready=1 after release.
